// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Groups the pipeline-facing signals of the hazard controller.
//   ID-stage operands : rs1_id, rs2_id, use_rs1_id, use_rs2_id
//   EX-stage status   : memread_ex, rd_ex, redirect_ex, ex_busy
//   Pipeline controls : pc_stall, ifid_stall, idex_stall, ifid_clr, idex_clr
//   Observability     : state, stall_cnt, flush_cnt
// Modports:
//   slave  - the hazard controller (consumes status, produces controls)
//   master - the pipeline / testbench (produces status, consumes controls)
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        use_rs1_id;
    logic        use_rs2_id;
    logic        memread_ex;
    logic [4:0]  rd_ex;
    logic        redirect_ex;
    logic        ex_busy;
    logic        pc_stall;
    logic        ifid_stall;
    logic        idex_stall;
    logic        ifid_clr;
    logic        idex_clr;
    logic [1:0]  state;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id,
        input  memread_ex, rd_ex, redirect_ex, ex_busy,
        output pc_stall, ifid_stall, idex_stall, ifid_clr, idex_clr,
        output state, stall_cnt, flush_cnt
    );

    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id,
        output memread_ex, rd_ex, redirect_ex, ex_busy,
        input  pc_stall, ifid_stall, idex_stall, ifid_clr, idex_clr,
        input  state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a 5-stage in-order core. Detects load-use
// hazards, flushes IF/ID and ID/EX on EX redirects, and freezes the front of
// the pipe while a multi-cycle EX operation is in progress. Also keeps
// saturating performance counters of stall and flush cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   hz   - hazard_ctrl_if.slave bundle (operands, EX status, controls,
//          FSM state and counters)
// Control outputs are combinational from the current state and inputs;
// state and counters are registered.
// -----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    // Encoding 2'd1 is reserved and never entered.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd2,
        ST_EX_WAIT = 2'd3
    } state_e;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    state_e      state_r;
    state_e      state_next_s;
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    logic        rs1_hit_s;
    logic        rs2_hit_s;
    logic        lu_s;
    logic        redirect_ok_s;
    logic        flush_inc_s;
    logic        pc_stall_s;
    logic        ifid_stall_s;
    logic        idex_stall_s;
    logic        ifid_clr_s;
    logic        idex_clr_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        logic [31:0] res;
        if (en && (val != CNT_MAX)) begin
            res = val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Load-use detection; x0 is hard-wired zero so it can never be a hazard.
    always_comb begin
        rs1_hit_s = hz.use_rs1_id && (hz.rs1_id == hz.rd_ex);
        rs2_hit_s = hz.use_rs2_id && (hz.rs2_id == hz.rd_ex);
        lu_s      = hz.memread_ex && (hz.rd_ex != 5'd0) && (rs1_hit_s || rs2_hit_s);
    end

    // Next-state and control outputs; priority is ex_busy > redirect > load-use.
    always_comb begin
        state_next_s  = ST_RUN;
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        idex_stall_s  = 1'b0;
        ifid_clr_s    = 1'b0;
        idex_clr_s    = 1'b0;
        flush_inc_s   = 1'b0;

        // In FLUSH the EX stage holds the bubble we just inserted, so any
        // redirect seen there is stale and must be ignored.
        case (state_r)
            ST_FLUSH: redirect_ok_s = 1'b0;
            ST_RUN:   redirect_ok_s = 1'b1;
            ST_EX_WAIT: redirect_ok_s = 1'b1;
            default:  redirect_ok_s = 1'b1;
        endcase

        if (rst) begin
            state_next_s = ST_RUN;
        end else if (hz.ex_busy) begin
            pc_stall_s   = 1'b1;
            ifid_stall_s = 1'b1;
            idex_stall_s = 1'b1;
            state_next_s = ST_EX_WAIT;
        end else if (hz.redirect_ex && redirect_ok_s) begin
            // A coincident load-use is moot: the dependent instruction is flushed.
            ifid_clr_s   = 1'b1;
            idex_clr_s   = 1'b1;
            flush_inc_s  = 1'b1;
            state_next_s = ST_FLUSH;
        end else if (lu_s) begin
            pc_stall_s   = 1'b1;
            ifid_stall_s = 1'b1;
            idex_clr_s   = 1'b1;
            state_next_s = ST_RUN;
        end else begin
            state_next_s = ST_RUN;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Saturating stall and flush performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= sat_inc(stall_cnt_r, pc_stall_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, flush_inc_s);
        end
    end

    assign hz.pc_stall   = pc_stall_s;
    assign hz.ifid_stall = ifid_stall_s;
    assign hz.idex_stall = idex_stall_s;
    assign hz.ifid_clr   = ifid_clr_s;
    assign hz.idex_clr   = idex_clr_s;
    assign hz.state      = state_r;
    assign hz.stall_cnt  = stall_cnt_r;
    assign hz.flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. A behavioural model tracks only two
// facts about the previous cycle (was EX busy, was a redirect accepted) plus
// the two counters, and derives the expected outputs from the hazard rules.
// A compare process checks every DUT output on every falling edge; directed
// scenarios add literal expectations, then a randomized run follows.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_ctrl_if ifc ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (ifc)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Model state: what happened in the previous cycle, plus counters.
    bit          m_busy_prev  = 1'b0;
    bit          m_flush_prev = 1'b0;
    logic [31:0] m_stall_cnt  = 32'd0;
    logic [31:0] m_flush_cnt  = 32'd0;

    // Expected values for the current cycle.
    bit          e_pc, e_ifs, e_ids, e_ifc, e_idc, e_accept;
    logic [1:0]  e_state;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: derive expected outputs and check every cycle.
    always @(negedge clk) begin
        bit lu;
        lu = ifc.memread_ex && (ifc.rd_ex != 5'd0) &&
             ((ifc.use_rs1_id && ifc.rs1_id == ifc.rd_ex) ||
              (ifc.use_rs2_id && ifc.rs2_id == ifc.rd_ex));
        {e_pc, e_ifs, e_ids, e_ifc, e_idc, e_accept} = 6'b0;
        if (rst) begin
            // everything quiet
        end else if (ifc.ex_busy) begin
            {e_pc, e_ifs, e_ids} = 3'b111;
        end else if (ifc.redirect_ex && !m_flush_prev) begin
            {e_ifc, e_idc, e_accept} = 3'b111;
        end else if (lu) begin
            {e_pc, e_ifs, e_idc} = 3'b111;
        end
        e_state = m_flush_prev ? 2'd2 : (m_busy_prev ? 2'd3 : 2'd0);

        chk("pc_stall",   {31'd0, ifc.pc_stall},   {31'd0, e_pc});
        chk("ifid_stall", {31'd0, ifc.ifid_stall}, {31'd0, e_ifs});
        chk("idex_stall", {31'd0, ifc.idex_stall}, {31'd0, e_ids});
        chk("ifid_clr",   {31'd0, ifc.ifid_clr},   {31'd0, e_ifc});
        chk("idex_clr",   {31'd0, ifc.idex_clr},   {31'd0, e_idc});
        chk("state",      {30'd0, ifc.state},      {30'd0, e_state});
        chk("stall_cnt",  ifc.stall_cnt,           m_stall_cnt);
        chk("flush_cnt",  ifc.flush_cnt,           m_flush_cnt);
    end

    // Model update at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_busy_prev  = 1'b0;
            m_flush_prev = 1'b0;
            m_stall_cnt  = 32'd0;
            m_flush_cnt  = 32'd0;
        end else begin
            m_busy_prev  = ifc.ex_busy;
            m_flush_prev = e_accept;
            if (e_pc && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 32'd1;
            if (e_accept && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt = m_flush_cnt + 32'd1;
        end
    end

    task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input bit mr,
                       input logic [4:0] rd, input bit redir, input bit busy);
        ifc.rs1_id      = rs1;
        ifc.rs2_id      = rs2;
        ifc.use_rs1_id  = u1;
        ifc.use_rs2_id  = u2;
        ifc.memread_ex  = mr;
        ifc.rd_ex       = rd;
        ifc.redirect_ex = redir;
        ifc.ex_busy     = busy;
    endtask

    task automatic idle();
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        chk("rst_state", {30'd0, ifc.state}, 32'd0);
        chk("rst_stall_cnt", ifc.stall_cnt, 32'd0);
        chk("rst_flush_cnt", ifc.flush_cnt, 32'd0);

        // Load-use on rs1.
        next();
        drv(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        settle();
        chk("lu_pc_stall", {31'd0, ifc.pc_stall}, 32'd1);
        chk("lu_ifid_stall", {31'd0, ifc.ifid_stall}, 32'd1);
        chk("lu_idex_clr", {31'd0, ifc.idex_clr}, 32'd1);
        chk("lu_idex_stall", {31'd0, ifc.idex_stall}, 32'd0);
        next();
        idle();
        settle();
        chk("lu_stall_cnt", ifc.stall_cnt, 32'd1);
        chk("lu_released", {31'd0, ifc.pc_stall}, 32'd0);

        // Index zero never hazards.
        next();
        drv(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        settle();
        chk("x0_pc_stall", {31'd0, ifc.pc_stall}, 32'd0);
        chk("x0_idex_clr", {31'd0, ifc.idex_clr}, 32'd0);

        // Redirect coincident with load-use: flush only.
        next();
        drv(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
        settle();
        chk("rd_lu_ifid_clr", {31'd0, ifc.ifid_clr}, 32'd1);
        chk("rd_lu_idex_clr", {31'd0, ifc.idex_clr}, 32'd1);
        chk("rd_lu_pc_stall", {31'd0, ifc.pc_stall}, 32'd0);
        next();
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        settle();
        chk("flush_state", {30'd0, ifc.state}, 32'd2);
        chk("flush_cnt_1", ifc.flush_cnt, 32'd1);
        chk("flush_ign_clr", {31'd0, ifc.ifid_clr}, 32'd0);
        chk("flush_stall_cnt", ifc.stall_cnt, 32'd1);
        next();
        idle();
        settle();
        chk("flush_cnt_hold", ifc.flush_cnt, 32'd1);
        chk("flush_back_run", {30'd0, ifc.state}, 32'd0);

        // Multi-cycle EX, from a fresh reset.
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            settle();
            chk("busy_stalls", {29'd0, ifc.pc_stall, ifc.ifid_stall, ifc.idex_stall}, 32'd7);
            chk("busy_no_clr", {30'd0, ifc.ifid_clr, ifc.idex_clr}, 32'd0);
            next();
        end
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        settle();
        chk("wait_state", {30'd0, ifc.state}, 32'd3);
        chk("wait_rel_clr", {30'd0, ifc.ifid_clr, ifc.idex_clr}, 32'd3);
        chk("wait_stall_cnt", ifc.stall_cnt, 32'd3);
        next();
        idle();
        settle();
        chk("wait_to_flush", {30'd0, ifc.state}, 32'd2);
        chk("wait_flush_cnt", ifc.flush_cnt, 32'd1);
        next();

        // Counter saturation: preload one below the ceiling.
        force dut.stall_cnt_r = 32'hFFFF_FFFE;
        force dut.flush_cnt_r = 32'hFFFF_FFFE;
        m_stall_cnt = 32'hFFFF_FFFE;
        m_flush_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_r;
        release dut.flush_cnt_r;
        drv(5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        next();
        settle();
        chk("sat_stall_top", ifc.stall_cnt, 32'hFFFF_FFFF);
        next();
        idle();
        settle();
        chk("sat_stall_hold", ifc.stall_cnt, 32'hFFFF_FFFF);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        next();
        idle();
        next();
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        next();
        idle();
        settle();
        chk("sat_flush_hold", ifc.flush_cnt, 32'hFFFF_FFFF);
        next();

        // Reset during EX_WAIT.
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        next();
        settle();
        chk("mid_wait_state", {30'd0, ifc.state}, 32'd3);
        rst = 1'b1;
        settle();
        chk("mid_rst_quiet", {27'd0, ifc.pc_stall, ifc.ifid_stall, ifc.idex_stall,
                              ifc.ifid_clr, ifc.idex_clr}, 32'd0);
        next();
        settle();
        chk("mid_rst_state", {30'd0, ifc.state}, 32'd0);
        chk("mid_rst_stall_cnt", ifc.stall_cnt, 32'd0);
        chk("mid_rst_flush_cnt", ifc.flush_cnt, 32'd0);
        chk("mid_rst_pc_stall", {31'd0, ifc.pc_stall}, 32'd0);
        rst = 1'b0;
        idle();
        next();

        // Randomized traffic with small index ranges to make hits likely.
        for (int i = 0; i < 3000; i++) begin
            drv(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            rst = ($urandom_range(0, 49) == 0);
            next();
        end

        rst = 1'b0;
        idle();
        next();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
